bpu_pht_ctrl: RTL and testbench

//  Controller for the branch prediction unit's pattern history table (PHT), built on DualPort_SRAM.

---
 rtl/bpu_pht_ctrl.sv | 135 +++++++++++++
 tb/tb_bpu_pht_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bpu_pht_ctrl.sv
// Pattern history table controller: port 1 serves prediction lookups, port 2 does
// read-modify-write of saturating counters. A two-entries-per-cycle sweep initialises the table after reset.
module bpu_pht_ctrl #(
   parameter int              PHT_DEPTH = 256,
   parameter int              CNT_W     = 2,
   parameter logic [CNT_W-1:0] INIT_CNT = 2'b01,
   localparam int             IDX_W     = $clog2(PHT_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_req,
   input  logic [IDX_W-1:0] pred_idx,
   output logic             pred_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic             upd_ready,
   output logic             init_done,
   output logic [IDX_W-1:0] sram_addr1,
   output logic [IDX_W-1:0] sram_addr2,
   output logic [CNT_W-1:0] sram_din1,
   output logic [CNT_W-1:0] sram_din2,
   output logic             sram_wen1,
   output logic             sram_wen2,
   input  logic [CNT_W-1:0] sram_dout1,
   input  logic [CNT_W-1:0] sram_dout2
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE} state_t;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             taken_reg;
   logic             init_done_reg;
   logic             pred_valid_reg;
   logic             fwd_valid_reg;
   logic             fwd_bit_reg;
   logic [CNT_W-1:0] cnt_new;
   logic             sweep_last;
   logic             pred_acc;
   logic             upd_acc;

   // ptr_reg is always even: it addresses the pair {ptr, ptr+1} each sweep cycle
   assign sweep_last = (ptr_reg == IDX_W'(PHT_DEPTH - 2));
   assign pred_acc   = pred_req & init_done_reg & ~rst;
   assign upd_acc    = upd_valid & upd_ready;

   assign pred_ready = init_done_reg;
   assign init_done  = init_done_reg;
   assign pred_valid = pred_valid_reg;
   // Bypass covers a lookup that raced the same-edge write of its entry
   assign pred_taken = pred_valid_reg & (fwd_valid_reg ? fwd_bit_reg : sram_dout1[CNT_W-1]);

   always_comb begin
      cnt_new = sram_dout2;
      if (taken_reg) begin
         if (!(&sram_dout2))
            cnt_new = sram_dout2 + CNT_W'(1);
      end else begin
         if (sram_dout2 != '0)
            cnt_new = sram_dout2 - CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      upd_ready  = 1'b0;
      sram_addr1 = '0;
      sram_addr2 = '0;
      sram_din1  = '0;
      sram_din2  = '0;
      sram_wen1  = 1'b0;
      sram_wen2  = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_INIT: begin
               sram_wen1  = 1'b1;
               sram_wen2  = 1'b1;
               sram_addr1 = ptr_reg;
               sram_addr2 = ptr_reg + IDX_W'(1);
               sram_din1  = INIT_CNT;
               sram_din2  = INIT_CNT;
               if (sweep_last)
                  state_next = S_IDLE;
            end
            S_IDLE: begin
               upd_ready  = 1'b1;
               sram_addr1 = pred_idx;
               sram_addr2 = upd_idx;
               if (upd_valid)
                  state_next = S_WRITE;
            end
            S_WRITE: begin
               sram_addr1 = pred_idx;
               sram_addr2 = idx_reg;
               sram_din2  = cnt_new;
               sram_wen2  = 1'b1;
               state_next = S_IDLE;
            end
            default: state_next = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_INIT;
         ptr_reg        <= '0;
         idx_reg        <= '0;
         taken_reg      <= 1'b0;
         init_done_reg  <= 1'b0;
         pred_valid_reg <= 1'b0;
         fwd_valid_reg  <= 1'b0;
         fwd_bit_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pred_valid_reg <= pred_acc;
         fwd_valid_reg  <= pred_acc && (state_reg == S_WRITE) && (pred_idx == idx_reg);
         fwd_bit_reg    <= cnt_new[CNT_W-1];
         if (state_reg == S_INIT) begin
            ptr_reg <= ptr_reg + IDX_W'(2);
            if (sweep_last)
               init_done_reg <= 1'b1;
         end
         if (upd_acc) begin
            idx_reg   <= upd_idx;
            taken_reg <= upd_taken;
         end
      end
   end

endmodule

// File: tb/tb_bpu_pht_ctrl.sv
// Bench for bpu_pht_ctrl: drives directed and random traffic cycle by cycle against
// a behavioural table model and a bench-owned dual-port SRAM.
module tb_bpu_pht_ctrl;

   localparam int DEPTH = 256;
   localparam int HALF  = DEPTH / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       pred_req, pred_ready, pred_valid, pred_taken;
   logic [7:0] pred_idx, upd_idx;
   logic       upd_valid, upd_taken, upd_ready, init_done;
   logic [7:0] sram_addr1, sram_addr2;
   logic [1:0] sram_din1, sram_din2, sram_dout1, sram_dout2;
   logic       sram_wen1, sram_wen2;

   logic [1:0] mem [DEPTH];
   int         wr2_cnt = 0;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int ref_cnt [DEPTH];
   int init_left;
   bit pend;
   int pend_idx;
   bit pend_taken;
   int accepts;

   always #5 clk = ~clk;

   bpu_pht_ctrl #(.PHT_DEPTH(DEPTH), .CNT_W(2), .INIT_CNT(2'b01)) dut (
      .clk(clk), .rst(rst),
      .pred_req(pred_req), .pred_idx(pred_idx), .pred_ready(pred_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_ready(upd_ready), .init_done(init_done),
      .sram_addr1(sram_addr1), .sram_addr2(sram_addr2),
      .sram_din1(sram_din1), .sram_din2(sram_din2),
      .sram_wen1(sram_wen1), .sram_wen2(sram_wen2),
      .sram_dout1(sram_dout1), .sram_dout2(sram_dout2)
   );

   always @(posedge clk) begin
      if (sram_wen1) mem[sram_addr1] <= sram_din1;
      if (sram_wen2) mem[sram_addr2] <= sram_din2;
      if (sram_wen2 && init_done) wr2_cnt <= wr2_cnt + 1;
      sram_dout1 <= mem[sram_addr1];
      sram_dout2 <= mem[sram_addr2];
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c < 3) ? c + 1 : 3;
      return (c > 0) ? c - 1 : 0;
   endfunction

   // One clock cycle: drive inputs, predict, check combinational outputs, clock, check results.
   task automatic cyc(input bit pr, input int pi, input bit uv, input int ui, input bit ut, input bit r);
      bit pacc, uacc, exp_ur;
      int exp_pt;
      pacc = 0; uacc = 0; exp_ur = 0; exp_pt = 0;
      pred_req = pr; pred_idx = pi[7:0];
      upd_valid = uv; upd_idx = ui[7:0]; upd_taken = ut; rst = r;
      #1;
      if (r) begin
         check("rst_upd_ready", upd_ready, 0);
         check("rst_wen2", sram_wen2, 0);
         pend = 0;
         init_left = HALF;
      end else begin
         check("pred_ready", pred_ready, (init_left == 0));
         check("init_done", init_done, (init_left == 0));
         if (init_left > 0) begin
            check("sweep_wen", {sram_wen1, sram_wen2}, 3);
            check("sweep_addr1", sram_addr1, 2 * (HALF - init_left));
            check("sweep_addr2", sram_addr2, 2 * (HALF - init_left) + 1);
            check("sweep_din", {sram_din1, sram_din2}, 5);
         end else begin
            if (pend) ref_cnt[pend_idx] = sat(ref_cnt[pend_idx], pend_taken);
            exp_ur = !pend;
            pacc = pr;
            uacc = uv && exp_ur;
            if (pacc) exp_pt = ref_cnt[pi] / 2;
         end
         check("upd_ready", upd_ready, exp_ur);
         pend = uacc; pend_idx = ui; pend_taken = ut;
         if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
               for (int i = 0; i < DEPTH; i++) ref_cnt[i] = 1;
         end
      end
      @(posedge clk); #1;
      check("pred_valid", pred_valid, pacc);
      if (pacc) check($sformatf("pred_taken[%0d]", pi), pred_taken, exp_pt);
      if (uacc) accepts++;
      $display("cyc rst=%0b pr=%0b pi=%0d uv=%0b ui=%0d ut=%0b -> pv=%0b pt=%0b ur_acc=%0b",
               r, pr, pi, uv, ui, ut, pred_valid, pred_taken, uacc);
   endtask

   task automatic check_mem_vs_model(input string tag);
      int diffs = 0;
      for (int i = 0; i < DEPTH; i++)
         if (int'(mem[i]) != ref_cnt[i]) diffs++;
      check(tag, diffs, 0);
   endtask

   initial begin
      int cycles, w0, a0;
      rst = 1'b1; pred_req = 0; pred_idx = 0; upd_valid = 0; upd_idx = 0; upd_taken = 0;
      init_left = HALF; pend = 0; accepts = 0;
      for (int i = 0; i < DEPTH; i++) ref_cnt[i] = 0;
      @(posedge clk); #1;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);

      // T1 + T6: sweep with requests ignored, init_done after exactly HALF cycles
      cycles = 0;
      while (init_left > 0) begin
         cyc(1, $urandom_range(0, 255), 1, $urandom_range(0, 255), 1, 0);
         cycles++;
      end
      check("init_cycles", cycles, HALF);
      check("init_done_after", init_done, 1);
      check_mem_vs_model("mem_after_init");
      for (int i = 0; i < DEPTH; i++) cyc(1, i, 0, 0, 0, 0);

      // T2: saturation on idx 5
      cyc(0, 0, 1, 5, 1, 0); cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 5, 1, 0); cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 0, 0);
      cyc(0, 0, 1, 5, 1, 0); cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 0, 0);
      check("t2_cnt_sat_hi", mem[5], 3);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 1, 5, 0, 0); cyc(1, 5, 0, 0, 0, 0);
      end
      check("t2_cnt_sat_lo", mem[5], 0);

      // T3: lookup in the WRITE cycle of the same index uses the bypass
      cyc(0, 0, 1, 9, 1, 0);
      cyc(1, 9, 0, 0, 0, 0);
      cyc(1, 9, 0, 0, 0, 0);

      // T4: upd_valid held six cycles -> three accepts, three writes
      w0 = wr2_cnt; a0 = accepts;
      for (int k = 0; k < 6; k++) cyc(0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 1), 0);
      check("t4_accepts", accepts - a0, 3);
      check("t4_writes", wr2_cnt - w0, 3);
      cyc(0, 0, 0, 0, 0, 0);

      // Random traffic on a narrow index range to hit forwarding and hazards
      for (int k = 0; k < 1500; k++)
         cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), 0);
      cyc(0, 0, 0, 0, 0, 0);
      check_mem_vs_model("mem_after_random");

      // T5: reset during a WRITE cycle squashes the write
      cyc(0, 0, 1, 20, 1, 0); cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 20, 1, 0); cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 20, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      check("t5_squash", mem[20], ref_cnt[20]);
      for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cycles = 0;
      while (init_left > 0) begin
         cyc(1, 0, 1, 3, 1, 0);
         cycles++;
      end
      check("t5_reinit_cycles", cycles, HALF);
      check_mem_vs_model("mem_after_reinit");
      for (int i = 0; i < DEPTH; i += 17) cyc(1, i, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
